network_sink: RTL and testbench

//  Return-path counterpart of the stream source: collects per-timestep output fire bits from the

---
 rtl/network_sink.sv | 64 ++++++
 tb/tb_network_sink.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/network_sink.sv
// Run-length packs per-timestep fire vectors into {idle_run, fires} packets for the host.
// Latency: 1 clk from accepted timestep to snk_valid.
// Backpressure: net_ready drops while a packet is held and snk_ready is low; every step stalls then.
module network_sink #(
    parameter int NUM_OUT   = 8,
    parameter int RUN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         net_valid,
    output logic                         net_ready,
    input  logic                         net_last,
    input  logic [0:NUM_OUT-1]           net_out,
    output logic                         snk_valid,
    input  logic                         snk_ready,
    output logic [RUN_WIDTH+NUM_OUT-1:0] snk
);

    typedef struct packed {
        logic [RUN_WIDTH-1:0] run;
        logic [NUM_OUT-1:0]   fires;
    } pkt_t;

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [RUN_WIDTH-1:0] CNT_MAX = '1;

    state_t               state;
    pkt_t                 pkt_q;
    logic [RUN_WIDTH-1:0] cnt;
    logic                 step;
    logic                 emit;

    assign net_ready = !rst && (!snk_valid || snk_ready);
    assign step      = net_valid && net_ready;
    // A saturated idle run is reported as its own packet so the counter never wraps.
    assign emit      = (|net_out) || net_last || (cnt == CNT_MAX);
    assign snk_valid = (state == FULL);
    assign snk       = pkt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            pkt_q <= '0;
            cnt   <= '0;
        end else begin
            if (step) begin
                if (emit) begin
                    pkt_q.run   <= cnt;
                    pkt_q.fires <= net_out;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            case (state)
                EMPTY: if (step && emit) state <= FULL;
                FULL:  if (snk_ready && !(step && emit)) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_network_sink.sv
// Directed bench for network_sink: reset, run-length packing, saturation, stall and reset recovery.
module tb_network_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        net_valid;
    logic        net_ready;
    logic        net_last;
    logic [0:7]  net_out;
    logic        snk_valid;
    logic        snk_ready;
    logic [15:0] snk;

    int checks = 0;
    int errors = 0;
    int early  = 0;

    network_sink #(.NUM_OUT(8), .RUN_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .net_valid (net_valid),
        .net_ready (net_ready),
        .net_last  (net_last),
        .net_out   (net_out),
        .snk_valid (snk_valid),
        .snk_ready (snk_ready),
        .snk       (snk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [0:7] v, input logic last);
        net_valid = 1'b1;
        net_out   = v;
        net_last  = last;
        tick();
        net_valid = 1'b0;
        net_out   = '0;
        net_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        net_valid = 1'b0;
        net_last  = 1'b0;
        net_out   = '0;
        snk_ready = 1'b1;

        // Reset behaviour
        tick();
        tick();
        chk("rst_snk_valid", snk_valid, 0);
        chk("rst_snk", snk, 0);
        chk("rst_net_ready", net_ready, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_net_ready", net_ready, 1);

        // Three idle steps then fires 00000101
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        chk("t2_no_early_pkt", snk_valid, 0);
        step(8'b00000101, 1'b0);
        chk("t2_valid", snk_valid, 1);
        chk("t2_pkt", snk, 16'h0305);
        tick();
        chk("t2_single_pkt", snk_valid, 0);

        // Saturation at 256 idle steps, then back-to-back fire on net_out[0]
        for (int i = 0; i < 256; i++) begin
            step(8'h00, 1'b0);
            if (i < 255 && snk_valid) early++;
        end
        chk("t3_no_early_pkt", early, 0);
        chk("t3_sat_valid", snk_valid, 1);
        chk("t3_sat_pkt", snk, 16'hFF00);
        chk("t3_ready_while_drain", net_ready, 1);
        step(8'b10000000, 1'b0);
        chk("t3_next_valid", snk_valid, 1);
        chk("t3_next_pkt", snk, 16'h0080);
        tick();
        chk("t3_drained", snk_valid, 0);

        // Backpressure: A held, B waits, then back-to-back
        snk_ready = 1'b0;
        step(8'h01, 1'b0);
        chk("t4_a_valid", snk_valid, 1);
        chk("t4_a_pkt", snk, 16'h0001);
        chk("t4_stall_ready", net_ready, 0);
        net_valid = 1'b1;
        net_out   = 8'h02;
        tick();
        chk("t4_a_held_valid", snk_valid, 1);
        chk("t4_a_held_pkt", snk, 16'h0001);
        snk_ready = 1'b1;
        #1;
        chk("t4_release_ready", net_ready, 1);
        tick();
        net_valid = 1'b0;
        net_out   = '0;
        chk("t4_b_valid", snk_valid, 1);
        chk("t4_b_pkt", snk, 16'h0002);
        tick();
        chk("t4_drained", snk_valid, 0);

        // net_last with zero fires closes the run
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b1);
        chk("t5_last_valid", snk_valid, 1);
        chk("t5_last_pkt", snk, 16'h0200);
        step(8'h01, 1'b0);
        chk("t5_cnt_cleared", snk, 16'h0001);
        tick();
        chk("t5_drained", snk_valid, 0);

        // Reset discards a pending packet and a partial run
        snk_ready = 1'b0;
        step(8'h40, 1'b0);
        chk("t6_pending_pkt", snk, 16'h0040);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", snk_valid, 0);
        chk("t6_rst_snk", snk, 0);
        chk("t6_rst_ready", net_ready, 0);
        rst       = 1'b0;
        snk_ready = 1'b1;
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0);
        chk("t6_idle_no_pkt", snk_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step(8'h10, 1'b0);
        chk("t6_post_rst_valid", snk_valid, 1);
        chk("t6_post_rst_pkt", snk, 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
